// File: rtl/vsync.sv
// Vertical timing generator for 640x480@60 VGA: line/frame counters, VGA_VSYNC and 120-row VPIXEL index.
// Build option: define VSYNC_ACTIVE_HIGH_EN for an active-high VGA_VSYNC pulse.
`timescale 1ns/1ps
module vsync #(
  parameter int CLKS_PER_LINE    = 1600,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int LINES_PER_VPIXEL = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] VPIXEL,
  output logic       VGA_VSYNC
);

  localparam int LINES_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] CLK_LAST    = 11'(CLKS_PER_LINE - 1);
  localparam logic [9:0]  SYNC_LAST   = 10'(V_SYNC - 1);
  localparam logic [9:0]  BP_LAST     = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0]  ACTIVE_LAST = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  LINE_LAST   = 10'(LINES_TOTAL - 1);
  localparam logic [1:0]  SUB_LAST    = 2'(LINES_PER_VPIXEL - 1);

`ifdef VSYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_LEVEL = 1'b1;
`else
  localparam logic SYNC_LEVEL = 1'b0;
`endif

  typedef enum logic [1:0] {
    SYNC,
    BACK_PORCH,
    ACTIVE,
    FRONT_PORCH
  } state_t;

  logic [10:0] clk_cnt_reg, clk_cnt_next;
  logic [9:0]  line_cnt_reg, line_cnt_next;
  state_t      state_reg, state_next;
  logic [1:0]  sub_row_reg, sub_row_next;
  logic [6:0]  vpixel_reg, vpixel_next;
  logic        vsync_reg, vsync_next;
  logic        line_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt_reg  <= '0;
      line_cnt_reg <= '0;
      state_reg    <= SYNC;
      sub_row_reg  <= '0;
      vpixel_reg   <= '0;
      vsync_reg    <= SYNC_LEVEL;
    end else begin
      clk_cnt_reg  <= clk_cnt_next;
      line_cnt_reg <= line_cnt_next;
      state_reg    <= state_next;
      sub_row_reg  <= sub_row_next;
      vpixel_reg   <= vpixel_next;
      vsync_reg    <= vsync_next;
    end
  end

  always_comb begin
    line_wrap     = (clk_cnt_reg == CLK_LAST);
    clk_cnt_next  = clk_cnt_reg + 11'd1;
    line_cnt_next = line_cnt_reg;
    state_next    = state_reg;
    sub_row_next  = sub_row_reg;
    vpixel_next   = vpixel_reg;
    vsync_next    = vsync_reg;

    if (line_wrap) begin
      clk_cnt_next  = '0;
      line_cnt_next = (line_cnt_reg == LINE_LAST) ? 10'd0 : line_cnt_reg + 10'd1;

      // Transitions are keyed on the line being left, so outputs track the new line on this edge.
      case (state_reg)
        SYNC:        if (line_cnt_reg == SYNC_LAST)   state_next = BACK_PORCH;
        BACK_PORCH:  if (line_cnt_reg == BP_LAST)     state_next = ACTIVE;
        ACTIVE:      if (line_cnt_reg == ACTIVE_LAST) state_next = FRONT_PORCH;
        FRONT_PORCH: if (line_cnt_reg == LINE_LAST)   state_next = SYNC;
        default:     state_next = SYNC;
      endcase

      // Row index only advances while staying in ACTIVE; entering or leaving it restarts at row 0.
      if (state_reg == ACTIVE && state_next == ACTIVE) begin
        if (sub_row_reg == SUB_LAST) begin
          sub_row_next = '0;
          vpixel_next  = vpixel_reg + 7'd1;
        end else begin
          sub_row_next = sub_row_reg + 2'd1;
        end
      end else begin
        sub_row_next = '0;
        vpixel_next  = '0;
      end

      vsync_next = (state_next == SYNC) ? SYNC_LEVEL : ~SYNC_LEVEL;
    end
  end

  assign VPIXEL    = vpixel_reg;
  assign VGA_VSYNC = vsync_reg;

endmodule

// File: tb/tb_vsync.sv
// Self-checking bench for vsync: a line-scaled instance for whole-frame checks plus a full-rate instance.
`timescale 1ns/1ps
module tb_vsync;

  localparam int CPL      = 16;
  localparam int CPL_FULL = 1600;
  localparam int LINES    = 525;
  localparam int FRAME    = CPL * LINES;

`ifdef VSYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_LVL = 1'b1;
`else
  localparam logic SYNC_LVL = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] vpixel, vpixel_full;
  logic       vsync_o, vsync_full;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint n        = 0;

  always #10 clk = ~clk;

  vsync #(.CLKS_PER_LINE(CPL)) dut (
    .clk      (clk),
    .reset    (reset),
    .VPIXEL   (vpixel),
    .VGA_VSYNC(vsync_o)
  );

  vsync dut_full (
    .clk      (clk),
    .reset    (reset),
    .VPIXEL   (vpixel_full),
    .VGA_VSYNC(vsync_full)
  );

  // Reference model: position in the frame derived purely from clocks elapsed since reset release.
  function automatic int line_of(longint cyc, int cpl);
    return int'((cyc / cpl) % LINES);
  endfunction

  function automatic logic exp_vsync(longint cyc, int cpl);
    return (line_of(cyc, cpl) < 2) ? SYNC_LVL : ~SYNC_LVL;
  endfunction

  function automatic logic [6:0] exp_vpixel(longint cyc, int cpl);
    int l;
    l = line_of(cyc, cpl);
    if (l >= 35 && l < 515) return 7'((l - 35) / 4);
    return 7'd0;
  endfunction

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks += 4;
      if (vsync_o !== SYNC_LVL) begin n_fail++; $display("FAIL reset_vsync got %b want %b", vsync_o, SYNC_LVL); end
      if (vpixel !== 7'd0) begin n_fail++; $display("FAIL reset_vpixel got %0d want 0", vpixel); end
      if (vsync_full !== SYNC_LVL) begin n_fail++; $display("FAIL reset_vsync_full got %b want %b", vsync_full, SYNC_LVL); end
      if (vpixel_full !== 7'd0) begin n_fail++; $display("FAIL reset_vpixel_full got %0d want 0", vpixel_full); end
    end
    $display("reset held: outputs checked over 5 cycles");
  endtask

  task automatic test_frame_timing();
    longint last_start;
    logic   prev_asserted, asserted;
    int     starts;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    last_start = 0;
    prev_asserted = 1'b1;
    starts = 0;
    for (int i = 0; i < 2 * FRAME + 200; i++) begin
      @(posedge clk); #1;
      n++;
      n_checks += 2;
      if (vsync_o !== exp_vsync(n, CPL)) begin n_fail++; $display("FAIL frame_vsync n=%0d got %b want %b", n, vsync_o, exp_vsync(n, CPL)); end
      if (vpixel !== exp_vpixel(n, CPL)) begin n_fail++; $display("FAIL frame_vpixel n=%0d got %0d want %0d", n, vpixel, exp_vpixel(n, CPL)); end
      if (n <= 3300) begin
        n_checks += 2;
        if (vsync_full !== exp_vsync(n, CPL_FULL)) begin n_fail++; $display("FAIL full_vsync n=%0d got %b want %b", n, vsync_full, exp_vsync(n, CPL_FULL)); end
        if (vpixel_full !== 7'd0) begin n_fail++; $display("FAIL full_vpixel n=%0d got %0d want 0", n, vpixel_full); end
      end
      if (n == 39 * CPL || n == 511 * CPL || n == 515 * CPL - 1 || n == 515 * CPL) begin
        n_checks++;
        if (vpixel !== ((n == 39 * CPL) ? 7'd1 : (n == 515 * CPL) ? 7'd0 : 7'd119)) begin
          n_fail++; $display("FAIL vpixel_milestone n=%0d got %0d", n, vpixel);
        end
        $display("milestone n=%0d line=%0d vpixel=%0d", n, line_of(n, CPL), vpixel);
      end
      asserted = (vsync_o === SYNC_LVL);
      if (asserted && !prev_asserted) begin
        starts++;
        n_checks++;
        if (n - last_start != FRAME) begin n_fail++; $display("FAIL sync_period got %0d want %0d", n - last_start, FRAME); end
        $display("sync start n=%0d period=%0d", n, n - last_start);
        last_start = n;
      end
      if (!asserted && prev_asserted) begin
        n_checks++;
        if (n - last_start != 2 * CPL) begin n_fail++; $display("FAIL sync_width got %0d want %0d", n - last_start, 2 * CPL); end
        $display("sync end n=%0d width=%0d", n, n - last_start);
      end
      prev_asserted = asserted;
    end
    n_checks++;
    if (starts != 2) begin n_fail++; $display("FAIL sync_count got %0d want 2", starts); end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (!(line_of(n, CPL) == 200 && (n % CPL) == 3) && guard < FRAME) begin
      @(posedge clk); #1;
      n++;
      guard++;
      n_checks += 2;
      if (vsync_o !== exp_vsync(n, CPL)) begin n_fail++; $display("FAIL seek_vsync n=%0d got %b want %b", n, vsync_o, exp_vsync(n, CPL)); end
      if (vpixel !== exp_vpixel(n, CPL)) begin n_fail++; $display("FAIL seek_vpixel n=%0d got %0d want %0d", n, vpixel, exp_vpixel(n, CPL)); end
    end
    n_checks++;
    if (vpixel !== 7'd41) begin n_fail++; $display("FAIL line200_vpixel got %0d want 41", vpixel); end
    #4 reset = 1'b0;
    #1;
    n_checks += 4;
    if (vsync_o !== SYNC_LVL) begin n_fail++; $display("FAIL async_vsync got %b want %b", vsync_o, SYNC_LVL); end
    if (vpixel !== 7'd0) begin n_fail++; $display("FAIL async_vpixel got %0d want 0", vpixel); end
    if (vsync_full !== SYNC_LVL) begin n_fail++; $display("FAIL async_vsync_full got %b want %b", vsync_full, SYNC_LVL); end
    if (vpixel_full !== 7'd0) begin n_fail++; $display("FAIL async_vpixel_full got %0d want 0", vpixel_full); end
    @(posedge clk); #1;
    n_checks++;
    if (vsync_o !== SYNC_LVL || vpixel !== 7'd0) begin n_fail++; $display("FAIL held_reset got %b/%0d want %b/0", vsync_o, vpixel, SYNC_LVL); end
    $display("mid-frame reset at line 200 applied");
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 3400; i++) begin
      @(posedge clk); #1;
      n++;
      n_checks += 4;
      if (vsync_o !== exp_vsync(n, CPL)) begin n_fail++; $display("FAIL rerun_vsync n=%0d got %b want %b", n, vsync_o, exp_vsync(n, CPL)); end
      if (vpixel !== exp_vpixel(n, CPL)) begin n_fail++; $display("FAIL rerun_vpixel n=%0d got %0d want %0d", n, vpixel, exp_vpixel(n, CPL)); end
      if (vsync_full !== exp_vsync(n, CPL_FULL)) begin n_fail++; $display("FAIL rerun_full_vsync n=%0d got %b want %b", n, vsync_full, exp_vsync(n, CPL_FULL)); end
      if (vpixel_full !== exp_vpixel(n, CPL_FULL)) begin n_fail++; $display("FAIL rerun_full_vpixel n=%0d got %0d want %0d", n, vpixel_full, exp_vpixel(n, CPL_FULL)); end
    end
    $display("restart after reset: 3400 cycles checked");
  endtask

  task automatic test_back_to_back_resets();
    int run_len;
    int hold;
    for (int k = 0; k < 5; k++) begin
      run_len = (k == 4) ? 200 : int'($urandom_range(100, 4000));
      for (int i = 0; i < run_len; i++) begin
        @(posedge clk); #1;
        n++;
        n_checks += 2;
        if (vsync_o !== exp_vsync(n, CPL)) begin n_fail++; $display("FAIL rand_vsync k=%0d n=%0d got %b want %b", k, n, vsync_o, exp_vsync(n, CPL)); end
        if (vpixel !== exp_vpixel(n, CPL)) begin n_fail++; $display("FAIL rand_vpixel k=%0d n=%0d got %0d want %0d", k, n, vpixel, exp_vpixel(n, CPL)); end
      end
      $display("random run k=%0d len=%0d ends line=%0d", k, run_len, line_of(n, CPL));
      if (k == 4) break;
      #($urandom_range(1, 7)) reset = 1'b0;
      #1;
      n_checks++;
      if (vsync_o !== SYNC_LVL || vpixel !== 7'd0) begin n_fail++; $display("FAIL rand_reset k=%0d got %b/%0d want %b/0", k, vsync_o, vpixel, SYNC_LVL); end
      hold = int'($urandom_range(0, 3));
      repeat (hold) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      n = 0;
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_mid_reset();
    test_back_to_back_resets();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
